pair_encoder: RTL and testbench
===============================

# pair_encoder

Transmit-side counterpart of the SHA_256 two-lane pattern decoder. It accepts a stream of m-bit words through a valid/ready handshake and buffers them in a small FIFO. Each word is scrambled with a self-advancing shift-complement key and emitted as a complementary lane pair (data_o[0], data_o[1]) with its own valid/ready handshake. The decoder side can regenerate the key sequence and undo the scrambling.

## Interface
- m, 8: word width in bits (m ≥ 2).
- DEPTH, 4: input FIFO depth in words; must be a power of 2, ≥ 2.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous and active-low.
- data_i  input  m  input word.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  FIFO can accept a word (registered).
- data_o  output  m × [0:1] (unpacked)  [0] = scrambled word, [1] = bitwise complement of [0].
- valid_o  output  1  data_o pair is valid.
- ready_i  input  1  downstream accepts the pair.

## Operation
- Input accept: occurs on an edge where valid_i && ready_o. data_i is written at the FIFO write pointer and the count is incremented.
- FIFO: DEPTH entries with log2(DEPTH)-bit wrapping read/write pointers and a (log2(DEPTH)+1)-bit count. A push and a pop in the same cycle leave the count unchanged.
- ready_o next value = (count_next < DEPTH).
  - ready_o is therefore 0 while the FIFO is full; no write is ever attempted to a full FIFO.
  - A pop in the full cycle reasserts ready_o on the following edge.
- Key register k (m bits), reset value 0:
  - On every FIFO pop, k ← (~k) << 1, with a zero shifted into the LSB.
  - For m=8 the sequence is 0x00, 0xFE, 0x02, 0xFA, 0x0A, …
- Stage A (encode): register a_d, flag a_v.
  - On a pop, a_d ← fifo_head ^ k, using the pre-update value of k, and a_v ← 1.
  - A pop occurs when the FIFO is not empty and stage A is free or advancing in this cycle.
- Stage B (output): data_o[0], valid_o.
  - Stage B loads from stage A when a_v && (!valid_o || ready_i).
  - On load: data_o[0] ← a_d, data_o[1] ← ~a_d, valid_o ← 1.
  - If valid_o && ready_i and stage A holds nothing, valid_o ← 0 and data_o keeps its old value.
- Stage A is free when !a_v. It advances when stage B loads from it.
- Backpressure: while valid_o && !ready_i:
  - data_o and valid_o hold stable;
  - stage A holds;
  - the FIFO keeps accepting input until it is full.
- Invariant: data_o[1] == ~data_o[0] at all times, including reset (0x00 / 0xFF).

## Timing
- Reset (rst_i = 0, asynchronous), all of the following take effect immediately:
  - data_o[0] = 0, data_o[1] = all-ones, valid_o = 0, ready_o = 0;
  - k = 0, a_v = 0, count = 0, pointers = 0.
- After rst_i rises, ready_o = 1 from the first rising edge.
- Reset asserted mid-operation discards all buffered and in-flight words. The key restarts at 0.
- Latency: a word accepted on edge N, with the pipeline empty and ready_i = 1, is presented with valid_o = 1 after edge N+2.
- Throughput: 1 word/cycle sustained when ready_i = 1.
- Output handshake:
  - The pair transfers on an edge with valid_o && ready_i.
  - A new pair may be presented after that same edge with no bubble.
- Full FIFO with simultaneous pop: the pop is performed and no push occurs (ready_o was 0). The count becomes DEPTH−1.
- Pointer wrap: both pointers wrap modulo DEPTH. Data order is strictly FIFO across the wrap.

## Test plan
- Reset values: hold rst_i = 0, drive random inputs.
  - Required: valid_o = 0, ready_o = 0, data_o = {0x00, 0xFF}.
  - Release reset: ready_o = 1 after the first edge.
- Single word: m=8, push 0xA5 on edge N, ready_i = 1.
  - Required: after edge N+2, valid_o = 1 and data_o = {0xA5, 0x5A}.
  - Required: valid_o = 0 after edge N+3.
- Key sequence: back-to-back push of 0xA5, 0x3C, 0x00, 0xFF with ready_i = 1.
  - Required output pairs, on consecutive cycles: {0xA5,0x5A}, {0xC2,0x3D}, {0x02,0xFD}, {0x05,0xFA}.
- Backpressure and full: ready_i = 0, push continuously.
  - Required: output holds the first pair; exactly DEPTH+1 further words are accepted (FIFO + stage A), then ready_o = 0.
  - Raise ready_i: all words drain in order with the correct keys, and ready_o returns to 1 one edge after the first pop.
- Wrap-around: stream 3·DEPTH+1 words with random ready_i.
  - Required: every word is emitted once, in order, with data_o[0] ^ k_expected = input word and data_o[1] == ~data_o[0].
- Mid-stream reset: pulse rst_i low with 3 words buffered.
  - Required: outputs are at reset values immediately.
  - After release, the next word 0x11 emits as {0x11, 0xEE}, confirming the key restarts at 0.

Source files
------------

// File: rtl/pair_encoder.sv
// Buffers input words in a small FIFO, scrambles each word with a self-advancing
// shift-complement key, and emits it as a complementary lane pair.
module pair_encoder #(
  parameter int m     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [m-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [m-1:0] data_o [0:1],
  output logic         valid_o,
  input  logic         ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [m-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;

  logic [m-1:0]  key_q, key_d;
  logic [m-1:0]  a_data_q, a_data_d;
  logic          a_v_q, a_v_d;
  logic [m-1:0]  out_q, out_d;
  logic          valid_q, valid_d;

  logic          push;
  logic          pop;
  logic          b_load;
  logic [m-1:0]  fifo_head;

  assign fifo_head = mem_q[rptr_q];
  assign push      = valid_i && ready_q;
  assign b_load    = a_v_q && (!valid_q || ready_i);
  // Stage A can take a new word when empty or when its current word moves to B.
  assign pop       = (count_q != '0) && (!a_v_q || b_load);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    ready_d = (count_d < DEPTH_C);
  end

  always_comb begin
    key_d    = key_q;
    a_data_d = a_data_q;
    a_v_d    = a_v_q;
    if (pop) begin
      key_d    = {~key_q[m-2:0], 1'b0};
      a_data_d = fifo_head ^ key_q;
      a_v_d    = 1'b1;
    end else if (b_load) begin
      a_v_d    = 1'b0;
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (b_load) begin
      out_d   = a_data_q;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      key_q    <= '0;
      a_data_q <= '0;
      a_v_q    <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      key_q    <= key_d;
      a_data_q <= a_data_d;
      a_v_q    <= a_v_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  // Lane 1 is derived from lane 0 so the complement holds even in reset.
  assign data_o[0] = out_q;
  assign data_o[1] = ~out_q;
  assign valid_o   = valid_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_pair_encoder.sv
// Randomized self-checking bench for pair_encoder against a queue-based model.
module tb_pair_encoder;

  localparam int DEPTH = 4;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o [0:1];
  logic       valid_o;
  logic       ready_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] acc_q [$];
  logic [7:0] got_q [$];

  pair_encoder #(.m(8), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // n-th key after reset: start at zero, each step complement then shift left.
  function automatic logic [7:0] key_at(input int n);
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < n; i++) begin
      k = ~k;
      k = k << 1;
    end
    return k;
  endfunction

  // One clock: record the handshakes that happen on this edge into the model.
  task automatic tick();
    logic       acc, xfer;
    logic [7:0] din, dout;
    acc  = valid_i && ready_o;
    xfer = valid_o && ready_i;
    din  = data_i;
    dout = data_o[0];
    @(posedge clk_i);
    #1;
    if (acc)  acc_q.push_back(din);
    if (xfer) got_q.push_back(dout);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    rst_i   = 1'b0;
    #3;
    rst_i = 1'b1;
    acc_q.delete();
    got_q.delete();
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_i  = 8'($urandom);
      valid_i = 1'($urandom);
      ready_i = 1'($urandom);
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o[0] !== 8'h00 || data_o[1] !== 8'hFF) begin
        errors++;
        $display("FAIL reset_values: valid=%b ready=%b d0=%h d1=%h, expected 0 0 00 ff",
                 valid_o, ready_o, data_o[0], data_o[1]);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_i   = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", ready_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 1", ready_o);
    end
    acc_q.delete();
    got_q.delete();
  endtask

  task automatic test_single();
    do_reset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hA5;
    tick();
    valid_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid got %b expected 0 after N+1", valid_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o[0] !== 8'hA5 || data_o[1] !== 8'h5A) begin
      errors++;
      $display("FAIL single_out: valid=%b d0=%h d1=%h, expected 1 a5 5a", valid_o, data_o[0], data_o[1]);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_end: valid got %b expected 0 after N+3", valid_o);
    end
  endtask

  task automatic test_key_seq();
    logic [7:0] win [4];
    logic [7:0] exp0 [4];
    win  = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    exp0 = '{8'hA5, 8'hC2, 8'h02, 8'h05};
    do_reset();
    ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      valid_i = (c < 4);
      data_i  = (c < 4) ? win[c] : 8'h00;
      tick();
      if (c >= 2 && c <= 5) begin
        checks++;
        if (valid_o !== 1'b1 || data_o[0] !== exp0[c-2] || data_o[1] !== ~exp0[c-2]) begin
          errors++;
          $display("FAIL key_seq[%0d]: valid=%b d0=%h d1=%h, expected 1 %h %h",
                   c - 2, valid_o, data_o[0], data_o[1], exp0[c-2], ~exp0[c-2]);
        end
      end
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL key_seq_end: valid got %b expected 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    int budget;
    do_reset();
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int c = 0; c < 3 * DEPTH + 6; c++) begin
      data_i = 8'($urandom);
      tick();
      if (valid_o === 1'b1) begin
        checks++;
        if (data_o[0] !== acc_q[0] || data_o[1] !== ~acc_q[0]) begin
          errors++;
          $display("FAIL bp_hold: d0=%h d1=%h expected %h %h", data_o[0], data_o[1], acc_q[0], ~acc_q[0]);
        end
      end
    end
    checks++;
    if (acc_q.size() != DEPTH + 2) begin
      errors++;
      $display("FAIL bp_accepted: got %0d words expected %0d", acc_q.size(), DEPTH + 2);
    end
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: ready=%b valid=%b expected 0 1", ready_o, valid_o);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return: got %b expected 1", ready_o);
    end
    budget = 0;
    while (got_q.size() < acc_q.size() && budget < 50) begin
      tick();
      budget++;
    end
    checks++;
    if (got_q.size() != acc_q.size()) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d pairs expected %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (got_q[i] !== (acc_q[i] ^ key_at(i))) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got %h expected %h", i, got_q[i], acc_q[i] ^ key_at(i));
      end
    end
  endtask

  task automatic test_wrap();
    localparam int NW = 3 * DEPTH + 1;
    int cyc;
    do_reset();
    cyc = 0;
    while (got_q.size() < NW && cyc < 600) begin
      valid_i = (acc_q.size() < NW) && ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom);
      ready_i = (cyc > 400) ? 1'b1 : 1'($urandom);
      checks++;
      if (data_o[1] !== ~data_o[0]) begin
        errors++;
        $display("FAIL wrap_complement: d0=%h d1=%h", data_o[0], data_o[1]);
      end
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    checks++;
    if (got_q.size() != NW || acc_q.size() != NW) begin
      errors++;
      $display("FAIL wrap_count: got %0d pairs from %0d words expected %0d", got_q.size(), acc_q.size(), NW);
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if ((got_q[i] ^ key_at(i)) !== acc_q[i]) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_q[i], acc_q[i] ^ key_at(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = 8'($urandom);
      tick();
    end
    valid_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o[0] !== 8'h00 || data_o[1] !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b ready=%b d0=%h d1=%h, expected 0 0 00 ff",
               valid_o, ready_o, data_o[0], data_o[1]);
    end
    rst_i = 1'b1;
    acc_q.delete();
    got_q.delete();
    tick();
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h11;
    tick();
    valid_i = 1'b0;
    budget = 0;
    while (valid_o !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    checks++;
    if (valid_o !== 1'b1 || data_o[0] !== 8'h11 || data_o[1] !== 8'hEE) begin
      errors++;
      $display("FAIL mid_reset_restart: valid=%b d0=%h d1=%h, expected 1 11 ee", valid_o, data_o[0], data_o[1]);
    end
  endtask

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    #1;
    test_reset();
    test_single();
    test_key_seq();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
